// File: rtl/sam_pkg.sv
// Shared definitions for the SAM video address counter.
// Contents: FSM state encoding, video mode encodings, X/Y divide lookup and
// the shift that places the F register in the field base address.
package sam_pkg;

  // F occupies address bits [16:9] of the field start address.
  localparam int BASE_SHIFT = 9;

  typedef enum logic {
    WAIT_FIELD = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  // V[2:0] encodings. Codes not listed here, and any code with V[3]=1, divide by (1,1).
  localparam logic [2:0] MODE_X1Y12 = 3'b000;
  localparam logic [2:0] MODE_X1Y3  = 3'b001;
  localparam logic [2:0] MODE_X2Y3  = 3'b010;
  localparam logic [2:0] MODE_X1Y2  = 3'b011;
  localparam logic [2:0] MODE_X2Y2  = 3'b100;

  typedef struct packed {
    logic [1:0] xd;  // DA0 strobes per address increment
    logic [3:0] yd;  // HS strobes per line-start advance
  } div_t;

  function automatic div_t mode_div(input logic [3:0] v);
    div_t d;
    d.xd = 2'd1;
    d.yd = 4'd1;
    if (!v[3]) begin
      case (v[2:0])
        MODE_X1Y12: d.yd = 4'd12;
        MODE_X1Y3:  d.yd = 4'd3;
        MODE_X2Y3:  begin d.xd = 2'd2; d.yd = 4'd3; end
        MODE_X1Y2:  d.yd = 4'd2;
        MODE_X2Y2:  begin d.xd = 2'd2; d.yd = 4'd2; end
        default:    ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/sam_edge_sync.sv
// Two-flop synchroniser plus single-cycle edge detector for one async VDG strobe.
// Ports: clk, rst_n (async active-low), pin (async input), ev (1-clk pulse on the selected edge).
// Parameters: FALLING selects falling-edge detection; RST_VAL is the idle level the flops reset to.
module sam_edge_sync #(
  parameter bit FALLING = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic ev
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Combinational so that the consumer's register lands exactly 3 clk after the pin edge.
  assign ev = FALLING ? (~s2 & s3) : (s2 & ~s3);

endmodule

// File: rtl/sam_video_counter.sv
// VDG video fetch address generator for the SAM: loads base from F on field sync,
// steps by DA0 with X divide, and repeats or advances lines on HS with Y divide.
// Ports: clk, RESET (async active-low), F/V (register file), DA0/HS_n/FS_n (async VDG strobes),
//        VA (fetch address), LINE_ADV / FIELD_LOAD (1-clk status pulses).
// Build option SAM_VCOUNT_BANKWRAP_EN: address increment wraps inside the current 64K bank.
module sam_video_counter
  import sam_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [7:0]        F,
  input  logic [3:0]        V,
  input  logic              DA0,
  input  logic              HS_n,
  input  logic              FS_n,
  output logic [ADDR_W-1:0] VA,
  output logic              LINE_ADV,
  output logic              FIELD_LOAD
);

  logic da_ev, hs_ev, fs_ev;

  sam_edge_sync #(.FALLING(1'b0), .RST_VAL(1'b0)) u_da (
    .clk(clk), .rst_n(RESET), .pin(DA0), .ev(da_ev));
  sam_edge_sync #(.FALLING(1'b1), .RST_VAL(1'b1)) u_hs (
    .clk(clk), .rst_n(RESET), .pin(HS_n), .ev(hs_ev));
  sam_edge_sync #(.FALLING(1'b1), .RST_VAL(1'b1)) u_fs (
    .clk(clk), .rst_n(RESET), .pin(FS_n), .ev(fs_ev));

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] va_q, va_d;
  logic [ADDR_W-1:0] line_start_q, line_start_d;
  logic [1:0]        xdiv_q, xdiv_d;
  logic [3:0]        ydiv_q, ydiv_d;
  logic [3:0]        mode_q, mode_d;
  logic              line_adv_q, line_adv_d;
  logic              field_load_q, field_load_d;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] va_inc;
  div_t              div;

  always_comb begin
    base = '0;
    base[16:0] = {F, {BASE_SHIFT{1'b0}}};
  end

`ifdef SAM_VCOUNT_BANKWRAP_EN
  // Bits 16 and up select the bank and are held; only the low 16 bits count.
  assign va_inc = {va_q[ADDR_W-1:16], va_q[15:0] + 16'd1};
`else
  assign va_inc = va_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  // Divide ratios of the mode latched for the current line.
  assign div = mode_div(mode_q);

  always_comb begin
    state_d      = state_q;
    va_d         = va_q;
    line_start_d = line_start_q;
    xdiv_d       = xdiv_q;
    ydiv_d       = ydiv_q;
    mode_d       = mode_q;
    line_adv_d   = 1'b0;
    field_load_d = 1'b0;

    if (fs_ev) begin
      state_d      = ACTIVE;
      va_d         = base;
      line_start_d = base;
      xdiv_d       = 2'd0;
      ydiv_d       = 4'd0;
      mode_d       = V;
      field_load_d = 1'b1;
    end else if (state_q == ACTIVE) begin
      if (hs_ev) begin
        xdiv_d = 2'd0;
        mode_d = V;
        // >= so a mode switch that leaves ydiv past the new YD still advances.
        if (ydiv_q >= div.yd - 4'd1) begin
          ydiv_d       = 4'd0;
          line_start_d = va_q;
          line_adv_d   = 1'b1;
        end else begin
          ydiv_d = ydiv_q + 4'd1;
          va_d   = line_start_q;
        end
      end else if (da_ev) begin
        if (xdiv_q >= div.xd - 2'd1) begin
          va_d   = va_inc;
          xdiv_d = 2'd0;
        end else begin
          xdiv_d = xdiv_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q      <= WAIT_FIELD;
      va_q         <= '0;
      line_start_q <= '0;
      xdiv_q       <= 2'd0;
      ydiv_q       <= 4'd0;
      mode_q       <= 4'd0;
      line_adv_q   <= 1'b0;
      field_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      va_q         <= va_d;
      line_start_q <= line_start_d;
      xdiv_q       <= xdiv_d;
      ydiv_q       <= ydiv_d;
      mode_q       <= mode_d;
      line_adv_q   <= line_adv_d;
      field_load_q <= field_load_d;
    end
  end

  assign VA         = va_q;
  assign LINE_ADV   = line_adv_q;
  assign FIELD_LOAD = field_load_q;

endmodule

// File: tb/tb_sam_video_counter.sv
// Scoreboard bench for sam_video_counter: stimulus queues expected pulses (kind, VA, cycle)
// and expected VA snapshots; a negedge monitor pops and compares them.
// Build option SAM_VCOUNT_BANKWRAP_EN selects the expected bank-wrap result.
module tb_sam_video_counter;

  logic        clk = 1'b0;
  logic        RESET;
  logic [7:0]  F;
  logic [3:0]  V;
  logic        DA0, HS_n, FS_n;
  logic [16:0] VA;
  logic        LINE_ADV, FIELD_LOAD;

  always #5 clk = ~clk;

  sam_video_counter #(.ADDR_W(17)) dut (
    .clk(clk), .RESET(RESET), .F(F), .V(V), .DA0(DA0), .HS_n(HS_n), .FS_n(FS_n),
    .VA(VA), .LINE_ADV(LINE_ADV), .FIELD_LOAD(FIELD_LOAD));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          fl;   // 1 = FIELD_LOAD expected, 0 = LINE_ADV expected
    logic [16:0] va;
    int          cyc;
  } pulse_t;

  typedef struct {
    string       name;
    logic [16:0] va;
    bit          idle; // also require both pulse outputs low
  } snap_t;

  pulse_t pulse_q[$];
  snap_t  snap_q[$];
  bit     done = 1'b0;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic take(input bit fl);
    pulse_t p;
    vectors++;
    if (pulse_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got pulse at cyc %0d VA=%05h, required none",
               fl ? "FIELD_LOAD" : "LINE_ADV", cyc, VA);
    end else begin
      p = pulse_q.pop_front();
      if (p.fl != fl || VA !== p.va || cyc != p.cyc) begin
        miscompares++;
        $display("FAIL pulse: got %s VA=%05h cyc=%0d, required %s VA=%05h cyc=%0d",
                 fl ? "FIELD_LOAD" : "LINE_ADV", VA, cyc,
                 p.fl ? "FIELD_LOAD" : "LINE_ADV", p.va, p.cyc);
      end
    end
  endtask

  // Monitor: the only process that compares or counts.
  always @(negedge clk) begin
    snap_t s;
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      vectors++;
      if (VA !== s.va) begin
        miscompares++;
        $display("FAIL %s: VA=%05h required %05h", s.name, VA, s.va);
      end
      if (s.idle) begin
        vectors++;
        if ({LINE_ADV, FIELD_LOAD} !== 2'b00) begin
          miscompares++;
          $display("FAIL %s_pulses: LINE_ADV/FIELD_LOAD=%b%b required 00", s.name, LINE_ADV, FIELD_LOAD);
        end
      end
    end
    if (RESET === 1'b1) begin
      if (FIELD_LOAD !== 1'b0) take(1'b1);
      if (LINE_ADV !== 1'b0) take(1'b0);
    end
    if (done) begin
      vectors++;
      if (pulse_q.size() != 0) begin
        miscompares++;
        $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", pulse_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not complete, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap(input string name, input logic [16:0] va, input bit idle);
    snap_t s;
    s.name = name; s.va = va; s.idle = idle;
    snap_q.push_back(s);
    tick(1);
  endtask

  task automatic da_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      DA0 = 1'b1; tick(2);
      DA0 = 1'b0; tick(2);
    end
  endtask

  task automatic hs_pulse(input bit exp_adv, input logic [16:0] adv_va);
    pulse_t p;
    if (exp_adv) begin
      p.fl = 1'b0; p.va = adv_va; p.cyc = cyc + 3;
      pulse_q.push_back(p);
    end
    HS_n = 1'b0; tick(2);
    HS_n = 1'b1; tick(2);
  endtask

  task automatic fs_pulse(input logic [16:0] load_va, input bit with_hs);
    pulse_t p;
    p.fl = 1'b1; p.va = load_va; p.cyc = cyc + 3;
    pulse_q.push_back(p);
    FS_n = 1'b0;
    if (with_hs) HS_n = 1'b0;
    tick(2);
    FS_n = 1'b1; HS_n = 1'b1;
    tick(2);
  endtask

  initial begin
    logic [16:0] wrap_va;
`ifdef SAM_VCOUNT_BANKWRAP_EN
    wrap_va = 17'h10000;
`else
    wrap_va = 17'h00000;
`endif
    RESET = 1'b0; F = 8'h00; V = 4'h0; DA0 = 1'b0; HS_n = 1'b1; FS_n = 1'b1;
    tick(3);
    snap("reset", 17'h00000, 1'b1);
    RESET = 1'b1;
    tick(2);

    // 1: no field sync yet, DA0 and HS are ignored
    da_pulses(8);
    hs_pulse(1'b0, 17'h0);
    snap("wait_field", 17'h00000, 1'b1);

    // 2: field load, pulse timing checked via expected cycle
    F = 8'h04; V = 4'b0101;
    fs_pulse(17'h00800, 1'b0);
    snap("field_load", 17'h00800, 1'b1);

    // 3: (1,1) mode, one line of 32 bytes then advance; switch to mode 000 for next line
    da_pulses(32);
    snap("line_32", 17'h00820, 1'b0);
    V = 4'b0000;
    hs_pulse(1'b1, 17'h00820);
    snap("advance", 17'h00820, 1'b1);
    da_pulses(4);
    snap("next_line", 17'h00824, 1'b0);
    hs_pulse(1'b0, 17'h0);
    snap("rewind_to_line_start", 17'h00820, 1'b1);

    // 4: reload, Y divide by 12
    fs_pulse(17'h00800, 1'b0);
    for (int i = 0; i < 12; i++) begin
      da_pulses(32);
      if (i < 11) begin
        hs_pulse(1'b0, 17'h0);
        snap($sformatf("y12_repeat_%0d", i + 1), 17'h00800, 1'b0);
      end else begin
        hs_pulse(1'b1, 17'h00820);
        snap("y12_advance", 17'h00820, 1'b0);
      end
    end

    // 5: X divide by 2, then simultaneous FS and HS: load wins
    V = 4'b0100;
    fs_pulse(17'h00800, 1'b0);
    da_pulses(32);
    snap("x2_line", 17'h00810, 1'b0);
    fs_pulse(17'h00800, 1'b1);
    snap("fs_beats_hs", 17'h00800, 1'b1);

    // 6: top of address space, wrap behaviour
    F = 8'hFF; V = 4'b0101;
    fs_pulse(17'h1FE00, 1'b0);
    da_pulses(511);
    snap("top", 17'h1FFFF, 1'b0);
    da_pulses(1);
    snap("wrap", wrap_va, 1'b0);

    // Reset mid-line returns to idle and ignores strobes until the next field sync
    da_pulses(3);
    RESET = 1'b0;
    tick(1);
    snap("mid_reset", 17'h00000, 1'b1);
    RESET = 1'b1;
    tick(2);
    da_pulses(2);
    hs_pulse(1'b0, 17'h0);
    snap("after_reset", 17'h00000, 1'b1);

    tick(3);
    done = 1'b1;
  end

endmodule
